// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues imem reads for incoming PCs and buffers the
// returned words in order, tagged with PC and misalign flag, for decode.
`timescale 1ns/1ps
module instr_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic            pc_valid,
  output logic            pc_ready,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_misalign
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] slot_pc   [DEPTH];
  logic [XLEN-1:0] slot_data [DEPTH];
  logic [DEPTH-1:0] slot_mis;
  logic [DEPTH-1:0] slot_filled;

  logic [PW-1:0] alloc_ptr, fill_ptr, read_ptr;
  logic [CW-1:0] inflight, buffered, drop_cnt;

  logic [CW+1:0] occupancy;
  logic          credit;
  logic          owed;
  logic          fill_en, drop_en, pop;
  logic [CW-1:0] flush_drop;

  // Slots are reserved at request time, so stale responses count against credit.
  assign occupancy = {2'b00, inflight} + {2'b00, buffered} + {2'b00, drop_cnt};
  assign credit    = occupancy < (CW+2)'(DEPTH);

  assign imem_req  = pc_valid & credit & ~flush & ~rst;
  assign imem_addr = {pc_in[XLEN-1:2], 2'b00};
  assign pc_ready  = imem_req & imem_gnt;

  assign owed    = (inflight != '0) || (drop_cnt != '0);
  assign drop_en = imem_rvalid & (drop_cnt != '0);
  assign fill_en = imem_rvalid & (drop_cnt == '0) & (inflight != '0) & ~flush & ~rst;

  assign instr_valid    = buffered != '0;
  assign pop            = instr_valid & instr_ready & ~flush & ~rst;
  assign instr_out      = instr_valid ? slot_data[read_ptr] : '0;
  assign instr_pc       = instr_valid ? slot_pc[read_ptr]   : '0;
  assign instr_misalign = instr_valid ? slot_mis[read_ptr]  : 1'b0;

  // A response arriving in the flush cycle retires one owed fetch immediately.
  assign flush_drop = drop_cnt + inflight - CW'(imem_rvalid & owed);

  always_ff @(posedge clk) begin
    if (pc_ready) begin
      slot_pc[alloc_ptr]  <= pc_in;
      slot_mis[alloc_ptr] <= |pc_in[1:0];
    end
    if (fill_en) begin
      slot_data[fill_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      read_ptr    <= '0;
      inflight    <= '0;
      buffered    <= '0;
      drop_cnt    <= '0;
      slot_filled <= '0;
    end else if (flush) begin
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      read_ptr    <= '0;
      inflight    <= '0;
      buffered    <= '0;
      drop_cnt    <= flush_drop;
      slot_filled <= '0;
    end else begin
      if (pc_ready) begin
        alloc_ptr <= alloc_ptr + PW'(1);
      end
      if (pop) begin
        read_ptr              <= read_ptr + PW'(1);
        slot_filled[read_ptr] <= 1'b0;
      end
      if (fill_en) begin
        fill_ptr              <= fill_ptr + PW'(1);
        slot_filled[fill_ptr] <= 1'b1;
      end
      inflight <= inflight + CW'(pc_ready) - CW'(fill_en);
      buffered <= buffered + CW'(fill_en) - CW'(pop);
      drop_cnt <= drop_cnt - CW'(drop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rvalid && !owed))
        else $error("imem_rvalid with no outstanding fetch");
      assert (!(pop && !slot_filled[read_ptr]))
        else $error("pop of an unfilled slot");
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: expected entries go to a scoreboard
// queue, a negedge monitor pops and compares every consumed head entry.
`timescale 1ns/1ps
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [XLEN-1:0] pc_in;
  logic            pc_valid;
  logic            pc_ready;
  logic            flush;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr_out;
  logic [XLEN-1:0] instr_pc;
  logic            instr_misalign;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_misalign(instr_misalign)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [31:0] p, input logic m);
    exp_t e;
    e.data = d;
    e.pc   = p;
    e.mis  = m;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed head entry must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && !flush && instr_valid && instr_ready) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL pop_unexpected: got data 0x%0h pc 0x%0h, scoreboard empty", instr_out, instr_pc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_data", instr_out, e.data);
        chk("mon_pc", instr_pc, e.pc);
        chk("mon_misalign", {31'd0, instr_misalign}, {31'd0, e.mis});
      end
    end
  end

  initial begin
    rst = 1'b1; pc_in = '0; pc_valid = 1'b0; flush = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    tick(); tick();

    // Reset: request path forced off even with a valid PC and grant.
    pc_valid = 1'b1; imem_gnt = 1'b1; pc_in = 32'h40;
    @(negedge clk);
    chk("rst_imem_req", {31'd0, imem_req}, 0);
    chk("rst_pc_ready", {31'd0, pc_ready}, 0);
    tick();
    rst = 1'b0; pc_valid = 1'b0;
    @(negedge clk);
    chk("rst_instr_valid", {31'd0, instr_valid}, 0);
    chk("rst_instr_out", instr_out, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_misalign", {31'd0, instr_misalign}, 0);
    tick();

    // In-order stream, one-cycle memory latency, decode always ready.
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc_valid    = (i < 4);
      pc_in       = 32'(4 * i);
      imem_rvalid = (i > 0);
      imem_rdata  = 32'hA0 + 32'(i) - 32'd1;
      if (i > 0) push(32'hA0 + 32'(i) - 32'd1, 32'(4 * (i - 1)), 1'b0);
      @(negedge clk);
      if (i < 4) chk("t1_pc_ready", {31'd0, pc_ready}, 1);
      chk("t1_instr_valid", {31'd0, instr_valid}, (i >= 2) ? 32'd1 : 32'd0);
      tick();
    end
    imem_rvalid = 1'b0; pc_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("t1_drained", {31'd0, instr_valid}, 0);
    tick();

    // Backpressure: four slots consumed, then one pop frees exactly one.
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pc_valid    = 1'b1;
      pc_in       = 32'h20 + 32'(4 * i);
      imem_rvalid = (i > 0);
      imem_rdata  = 32'hC0 + 32'(i) - 32'd1;
      if (i > 0) push(32'hC0 + 32'(i) - 32'd1, 32'h20 + 32'(4 * (i - 1)), 1'b0);
      @(negedge clk);
      if (i < 4) chk("t2_pc_ready", {31'd0, pc_ready}, 1);
      else begin
        chk("t2_full_pc_ready", {31'd0, pc_ready}, 0);
        chk("t2_full_imem_req", {31'd0, imem_req}, 0);
      end
      tick();
    end
    imem_rvalid = 1'b0; pc_in = 32'h30;
    @(negedge clk);
    chk("t2_full_pc_ready2", {31'd0, pc_ready}, 0);
    chk("t2_full_imem_req2", {31'd0, imem_req}, 0);
    chk("t2_head_data", instr_out, 32'hC0);
    tick();
    @(negedge clk);
    chk("t2_hold_data", instr_out, 32'hC0);
    chk("t2_hold_pc", instr_pc, 32'h20);
    tick();
    instr_ready = 1'b1;
    @(negedge clk);
    chk("t2_pop_cycle_pc_ready", {31'd0, pc_ready}, 0);
    tick();
    instr_ready = 1'b0;
    @(negedge clk);
    chk("t2_one_more_accept", {31'd0, pc_ready}, 1);
    tick();
    @(negedge clk);
    chk("t2_full_again", {31'd0, pc_ready}, 0);
    tick();
    pc_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hC4;
    push(32'hC4, 32'h30, 1'b0);
    tick();
    imem_rvalid = 1'b0; instr_ready = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    chk("t2_drained", {31'd0, instr_valid}, 0);
    tick();

    // Flush with two in flight and two buffered.
    instr_ready = 1'b0;
    pc_valid = 1'b1; pc_in = 32'd8;
    @(negedge clk); chk("t3_acc0", {31'd0, pc_ready}, 1); tick();
    pc_in = 32'd12; imem_rvalid = 1'b1; imem_rdata = 32'h11;
    @(negedge clk); chk("t3_acc1", {31'd0, pc_ready}, 1); tick();
    pc_in = 32'd16; imem_rdata = 32'h22;
    @(negedge clk); chk("t3_acc2", {31'd0, pc_ready}, 1); tick();
    pc_in = 32'd20; imem_rvalid = 1'b0;
    @(negedge clk); chk("t3_acc3", {31'd0, pc_ready}, 1); tick();
    flush = 1'b1; pc_in = 32'h40; instr_ready = 1'b1;
    @(negedge clk);
    chk("t3_flush_valid_before", {31'd0, instr_valid}, 1);
    chk("t3_flush_imem_req", {31'd0, imem_req}, 0);
    chk("t3_flush_pc_ready", {31'd0, pc_ready}, 0);
    tick();
    flush = 1'b0; instr_ready = 1'b0; pc_in = 32'd100;
    imem_rvalid = 1'b1; imem_rdata = 32'hBB;
    @(negedge clk);
    chk("t3_post_flush_valid", {31'd0, instr_valid}, 0);
    chk("t3_post_flush_accept", {31'd0, pc_ready}, 1);
    tick();
    pc_valid = 1'b0; imem_rdata = 32'hCC;
    @(negedge clk); chk("t3_drop_bb", {31'd0, instr_valid}, 0); tick();
    imem_rdata = 32'hDD; push(32'hDD, 32'd100, 1'b0);
    @(negedge clk); chk("t3_drop_cc", {31'd0, instr_valid}, 0); tick();
    imem_rvalid = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    chk("t3_new_head_valid", {31'd0, instr_valid}, 1);
    chk("t3_new_head_pc", instr_pc, 32'd100);
    tick();
    @(negedge clk); chk("t3_drained", {31'd0, instr_valid}, 0); tick();

    // Flush coinciding with a response while three fetches are in flight.
    for (int i = 0; i < 3; i++) begin
      pc_valid = 1'b1; pc_in = 32'h200 + 32'(4 * i);
      @(negedge clk); chk("t4_acc", {31'd0, pc_ready}, 1); tick();
    end
    pc_valid = 1'b0; flush = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h31;
    @(negedge clk); chk("t4_flush_imem_req", {31'd0, imem_req}, 0); tick();
    flush = 1'b0; pc_valid = 1'b1; pc_in = 32'h300; imem_rdata = 32'h32;
    @(negedge clk);
    chk("t4_accept", {31'd0, pc_ready}, 1);
    chk("t4_valid_a", {31'd0, instr_valid}, 0);
    tick();
    pc_valid = 1'b0; imem_rdata = 32'h33;
    @(negedge clk); chk("t4_valid_b", {31'd0, instr_valid}, 0); tick();
    imem_rdata = 32'h44; push(32'h44, 32'h300, 1'b0);
    @(negedge clk); chk("t4_valid_c", {31'd0, instr_valid}, 0); tick();
    imem_rvalid = 1'b0;
    @(negedge clk);
    chk("t4_third_fills", {31'd0, instr_valid}, 1);
    chk("t4_third_data", instr_out, 32'h44);
    tick();
    @(negedge clk); chk("t4_drained", {31'd0, instr_valid}, 0); tick();

    // Misaligned PC travels with its entry; address is word-aligned.
    pc_valid = 1'b1; pc_in = 32'h6;
    @(negedge clk);
    chk("t5_imem_addr", imem_addr, 32'h4);
    chk("t5_pc_ready", {31'd0, pc_ready}, 1);
    tick();
    pc_valid = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h55;
    push(32'h55, 32'h6, 1'b1);
    tick();
    imem_rvalid = 1'b0;
    @(negedge clk);
    chk("t5_misalign", {31'd0, instr_misalign}, 1);
    tick();

    // Reset with three buffered entries and decode ready.
    instr_ready = 1'b0;
    pc_valid = 1'b1; pc_in = 32'h10; tick();
    pc_in = 32'h14; imem_rvalid = 1'b1; imem_rdata = 32'hE0; tick();
    pc_in = 32'h18; imem_rdata = 32'hE1; tick();
    pc_valid = 1'b0; imem_rdata = 32'hE2; tick();
    imem_rvalid = 1'b0; rst = 1'b1; instr_ready = 1'b1; pc_valid = 1'b1; pc_in = 32'h1C;
    @(negedge clk);
    chk("t6_buffered_before", {31'd0, instr_valid}, 1);
    chk("t6_rst_pc_ready", {31'd0, pc_ready}, 0);
    chk("t6_rst_imem_req", {31'd0, imem_req}, 0);
    tick();
    rst = 1'b0; instr_ready = 1'b0; pc_valid = 1'b0;
    @(negedge clk);
    chk("t6_valid", {31'd0, instr_valid}, 0);
    chk("t6_out", instr_out, 0);
    chk("t6_pc", instr_pc, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      pc_valid = 1'b1; pc_in = 32'h80 + 32'(4 * i);
      @(negedge clk);
      chk("t6_credit", {31'd0, pc_ready}, (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    pc_valid = 1'b0; instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imem_rvalid = 1'b1; imem_rdata = 32'hF0 + 32'(i);
      push(32'hF0 + 32'(i), 32'h80 + 32'(4 * i), 1'b0);
      tick();
    end
    imem_rvalid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("t6_drained", {31'd0, instr_valid}, 0);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage directly downstream of the program counter: accepts each PC value, issues an instruction-memory read for it, and queues the returned instruction words in order, each tagged with its PC, for decode.
- Handles a memory with variable response latency and discards stale fetches when a taken branch redirects the PC.
- Sits between Program_Counter (pc_out) and the decode/register-file stage.

Parameters:
- DEPTH, 4, number of slots (in-flight plus buffered instructions); power of two, minimum 2.
- XLEN, 32, PC and instruction width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- pc_in  in  XLEN  fetch address from the program counter.
- pc_valid  in  1  pc_in is valid.
- pc_ready  out  1  pc_in accepted this cycle.
- flush  in  1  branch redirect: drop all queued and in-flight fetches.
- imem_req  out  1  memory read request.
- imem_addr  out  XLEN  word-aligned read address.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data returned (in request order, at least 1 cycle after gnt).
- imem_rdata  in  XLEN  returned instruction word.
- instr_valid  out  1  head entry is valid.
- instr_ready  in  1  decode consumes the head entry.
- instr_out  out  XLEN  head instruction word.
- instr_pc  out  XLEN  PC of the head instruction.
- instr_misalign  out  1  head PC had pc[1:0] != 0.

Behaviour:
- Storage:
  - Ring of DEPTH slots, each holding pc, data, misalign and filled bits.
  - Three pointers (alloc, fill, read), each log2(DEPTH) bits, wrapping modulo DEPTH.
  - Counters: inflight (allocated but not filled), buffered (filled but not read), drop_cnt (stale responses still owed). Each is log2(DEPTH)+1 bits.
- Credit: credit = (inflight + buffered + drop_cnt) < DEPTH, computed from registered state only.
- Request path (combinational):
  - imem_req = pc_valid & credit & !flush.
  - imem_addr = {pc_in[XLEN-1:2], 2'b00}.
  - pc_ready = imem_req & imem_gnt.
- On a pc_ready cycle: write pc_in and misalign = |pc_in[1:0] to slot[alloc]; alloc++; inflight++.
- Response path, on imem_rvalid:
  - If drop_cnt != 0: discard the data and decrement drop_cnt.
  - Otherwise: write slot[fill].data; fill++; inflight--; buffered++.
  - A response is guaranteed a slot because credit was reserved at request time.
- Output:
  - First-word fall-through from slot[read]: instr_valid = (buffered != 0).
  - On instr_valid & instr_ready: read++; buffered--.
  - No bypass: data returned in cycle N is first visible at instr_valid in cycle N+1.
  - Instruction outputs hold stable while instr_valid=1 and instr_ready=0.
- Simultaneous events:
  - Alloc, fill and read may all occur in the same cycle; counters apply the net change.
  - With buffered==DEPTH (full), no request can be issued (credit=0). Pop and fill in the same cycle are legal.
- Flush, taking effect at the clock edge:
  - All pointers go to 0; buffered goes to 0.
  - drop_cnt <= drop_cnt + inflight - (imem_rvalid ? 1 : 0). The imem_rvalid response in that cycle is discarded.
  - inflight goes to 0.
  - No request is issued during the flush cycle. instr_ready in the flush cycle is ignored.
  - Next cycle: instr_valid=0, and a new pc is accepted if credit allows.
- Reset:
  - All pointers and counters go to 0.
  - instr_valid=0, imem_req=0 (forced for the reset cycle), pc_ready=0.
  - instr_out, instr_pc and instr_misalign read 0.
  - Memory must be reset by the same rst. Responses arriving after reset for pre-reset requests are illegal.
- Error checks:
  - imem_rvalid with inflight==0 and drop_cnt==0 is a protocol error: flag it with an assertion, ignore the response.
  - Misaligned PC: the fetch still proceeds; the flag travels with the entry.

Test Plan:
- Reset, then pc_in=0,4,8,12 with gnt=1 and rvalid one cycle later carrying data 0xA0..0xA3 -> instr_out/instr_pc pairs (0xA0,0), (0xA1,4), (0xA2,8), (0xA3,12) in order; first instr_valid 2 cycles after first pc_ready.
- instr_ready=0, DEPTH=4 -> after 4 accepted PCs pc_ready=0 and imem_req=0. One pop -> exactly one more PC is accepted the next cycle.
- Two requests in flight (pc 16, 20), two entries buffered, flush asserted -> instr_valid=0 next cycle. The next two rvalids (0xBB, 0xCC) are dropped. New pc=100 with data 0xDD -> head is (0xDD, 100).
- Flush in the same cycle as an rvalid with inflight=3 -> drop_cnt=2; exactly two further responses are discarded, the third fills.
- pc_in=0x6 -> imem_addr=0x4; the returned entry has instr_pc=0x6 and instr_misalign=1.
- rst asserted with 3 buffered entries and instr_ready=1 -> next cycle instr_valid=0, all counters 0, pc_ready=0 during reset.
